// File: rtl/icache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL,
    RESP
  } cacheState_e;

  localparam logic [31:0] POISON_WORD = 32'hDEAD_BEEF;

  function automatic int offWidth(input int lineWords, input int dataW);
    return $clog2(lineWords * (dataW / 8));
  endfunction

  function automatic int idxWidth(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tagWidth(input int addrW, input int sets, input int lineWords, input int dataW);
    return addrW - offWidth(lineWords, dataW) - idxWidth(sets);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: combinational read, synchronous writes,
// single-cycle flush of every valid bit.
module icache_line_store #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 25,
  parameter int IDX_W      = 4,
  parameter int WORD_W     = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flushAll,
  input  logic [IDX_W-1:0]  rdIdx,
  input  logic [WORD_W-1:0] rdWordSel,
  output logic              rdValid,
  output logic [TAG_W-1:0]  rdTag,
  output logic [DATA_W-1:0] rdWord,
  input  logic              wordWrEn,
  input  logic [IDX_W-1:0]  wrIdx,
  input  logic [WORD_W-1:0] wrWordSel,
  input  logic [DATA_W-1:0] wrWord,
  input  logic              tagWrEn,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic              wrValid
);

  logic [SETS-1:0]   validBits;
  logic [TAG_W-1:0]  tagArray  [SETS];
  logic [DATA_W-1:0] dataArray [SETS][LINE_WORDS];

  assign rdValid = validBits[rdIdx];
  assign rdTag   = tagArray[rdIdx];
  assign rdWord  = dataArray[rdIdx][rdWordSel];

  // Flush wins over a same-cycle tag write so a flushed refill never leaves a live line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      validBits <= '0;
    end else if (flushAll) begin
      validBits <= '0;
    end else if (tagWrEn) begin
      validBits[wrIdx] <= wrValid;
    end
  end

  // Tags and data are deliberately not reset; the valid bits alone gate their use.
  always_ff @(posedge clock) begin
    if (wordWrEn) begin
      dataArray[wrIdx][wrWordSel] <= wrWord;
    end
    if (tagWrEn) begin
      tagArray[wrIdx] <= wrTag;
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: hit detection, line refill FSM, flush handling and
// saturating hit/miss counters.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              instr_err,
  input  logic              flush,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rerr,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF_W  = offWidth(LINE_WORDS, DATA_W);
  localparam int IDX_W  = idxWidth(SETS);
  localparam int TAG_W  = tagWidth(ADDR_W, SETS, LINE_WORDS, DATA_W);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  cacheState_e state, nextState;

  logic [ADDR_W-1:0] pcReg;
  logic [ADDR_W-1:0] fetchWordAddr, latchWordAddr;
  logic [IDX_W-1:0]  fetchIdx, latchIdx;
  logic [TAG_W-1:0]  fetchTag, latchTag;
  logic [WORD_W-1:0] fetchSel, latchSel;
  logic [WORD_W-1:0] beatCnt;
  logic              errFlag, flushPending, errNow, lastBeat;
  logic [DATA_W-1:0] capturedWord;
  logic              accept, hit, beatWrite, flushAll, tagWrEn, wrValid;
  logic              rdValid;
  logic [TAG_W-1:0]  rdTag;
  logic [DATA_W-1:0] rdWord;

  assign fetchWordAddr = fetch_pc >> BYTE_W;
  assign latchWordAddr = pcReg >> BYTE_W;
  assign fetchIdx      = IDX_W'(fetch_pc >> OFF_W);
  assign fetchTag      = TAG_W'(fetch_pc >> (OFF_W + IDX_W));
  assign fetchSel      = WORD_W'(fetchWordAddr & ADDR_W'(LINE_WORDS - 1));
  assign latchIdx      = IDX_W'(pcReg >> OFF_W);
  assign latchTag      = TAG_W'(pcReg >> (OFF_W + IDX_W));
  assign latchSel      = WORD_W'(latchWordAddr & ADDR_W'(LINE_WORDS - 1));

  assign fetch_ready   = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign lastBeat      = (beatCnt == WORD_W'(LINE_WORDS - 1));
  assign errNow        = errFlag | mem_rerr;
  assign tagWrEn       = beatWrite & lastBeat;
  assign wrValid       = ~errNow & ~flushPending & ~flush;
  assign flushAll      = ((state == IDLE) & flush) | ((state == RESP) & (flushPending | flush));

  icache_line_store #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .WORD_W     (WORD_W)
  ) lineStore (
    .clock     (clock),
    .reset_n   (reset_n),
    .flushAll  (flushAll),
    .rdIdx     (fetchIdx),
    .rdWordSel (fetchSel),
    .rdValid   (rdValid),
    .rdTag     (rdTag),
    .rdWord    (rdWord),
    .wordWrEn  (beatWrite),
    .wrIdx     (latchIdx),
    .wrWordSel (beatCnt),
    .wrWord    (mem_rdata),
    .tagWrEn   (tagWrEn),
    .wrTag     (latchTag),
    .wrValid   (wrValid)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // A flush arriving with a fetch invalidates first, so that fetch is forced to miss.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    hit       = 1'b0;
    beatWrite = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_valid) begin
          accept = 1'b1;
          if (rdValid && (rdTag == fetchTag) && !flush) begin
            hit = 1'b1;
          end else begin
            nextState = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          nextState = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid) begin
          beatWrite = 1'b1;
          if (lastBeat) begin
            nextState = RESP;
          end
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // The requested word is captured as it streams past, so the response never needs a second read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcReg        <= '0;
      mem_req_addr <= '0;
      beatCnt      <= '0;
      errFlag      <= 1'b0;
      flushPending <= 1'b0;
      capturedWord <= '0;
      instruction  <= '0;
      instr_valid  <= 1'b0;
      instr_err    <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      instr_valid <= 1'b0;
      instr_err   <= 1'b0;
      if (accept) begin
        pcReg <= fetch_pc;
        if (hit) begin
          instruction <= rdWord;
          instr_valid <= 1'b1;
          if (hit_count != '1) begin
            hit_count <= hit_count + 32'd1;
          end
        end else begin
          mem_req_addr <= (fetch_pc >> OFF_W) << OFF_W;
          errFlag      <= 1'b0;
          beatCnt      <= '0;
          if (miss_count != '1) begin
            miss_count <= miss_count + 32'd1;
          end
        end
      end
      if (beatWrite) begin
        errFlag <= errNow;
        beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
        if (beatCnt == latchSel) begin
          capturedWord <= mem_rdata;
        end
        if (lastBeat) begin
          instr_valid <= 1'b1;
          instr_err   <= errNow;
          if (errNow) begin
            instruction <= DATA_W'(POISON_WORD);
          end else if (beatCnt == latchSel) begin
            instruction <= mem_rdata;
          end else begin
            instruction <= capturedWord;
          end
        end
      end
      if (state == RESP) begin
        flushPending <= 1'b0;
      end else if ((state != IDLE) && flush) begin
        flushPending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Directed self-checking bench for icache_direct_mapped with default parameters.
module tb_icache_direct_mapped;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_ready;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_err;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rerr = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clock = ~clock;

  icache_direct_mapped dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_ready   (fetch_ready),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_err     (instr_err),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .mem_rerr      (mem_rerr),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic fl);
    fetch_valid = valid;
    fetch_pc    = pc;
    flush       = fl;
    tick();
    fetch_valid = 1'b0;
    flush       = 1'b0;
  endtask

  // Serves one line refill: optional request stall, then two back-to-back beats.
  task automatic serveMiss(input string tag, input logic [31:0] expAddr, input logic [31:0] b0,
                           input logic [31:0] b1, input logic err1, input int reqStall,
                           input logic [31:0] expWord, input logic expErr);
    int waitCycles = 0;
    while (!mem_req_valid && waitCycles < 8) begin
      tick();
      waitCycles++;
    end
    checkOutput({tag, "_reqvalid"}, {31'd0, mem_req_valid}, 32'd1);
    checkOutput({tag, "_reqaddr"}, mem_req_addr, expAddr);
    repeat (reqStall) tick();
    checkOutput({tag, "_reqhold"}, {mem_req_valid, mem_req_addr[30:0]}, {1'b1, expAddr[30:0]});
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = b0;
    mem_rerr   = 1'b0;
    tick();
    mem_rdata = b1;
    mem_rerr  = err1;
    tick();
    mem_rvalid = 1'b0;
    mem_rerr   = 1'b0;
    checkOutput({tag, "_rvalid"}, {31'd0, instr_valid}, 32'd1);
    checkOutput({tag, "_rword"}, instruction, expWord);
    checkOutput({tag, "_rerr"}, {31'd0, instr_err}, {31'd0, expErr});
    tick();
    checkOutput({tag, "_pulse"}, {31'd0, instr_valid}, 32'd0);
    checkOutput({tag, "_ready"}, {31'd0, fetch_ready}, 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) tick();
    checkOutput("rst_ready", {31'd0, fetch_ready}, 32'd1);
    checkOutput("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_ierr", {31'd0, instr_err}, 32'd0);
    checkOutput("rst_instr", instruction, 32'd0);
    checkOutput("rst_reqvalid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("rst_reqaddr", mem_req_addr, 32'd0);
    checkOutput("rst_hits", hit_count, 32'd0);
    checkOutput("rst_misses", miss_count, 32'd0);
    reset_n = 1'b1;
    tick();

    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("cold_busy", {31'd0, fetch_ready}, 32'd0);
    serveMiss("cold", 32'h100, 32'hAAAA0000, 32'hAAAA0001, 1'b0, 0, 32'hAAAA0000, 1'b0);
    checkOutput("cold_misses", miss_count, 32'd1);

    applyStimulus(1'b1, 32'h104, 1'b0);
    checkOutput("hit_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("hit_word", instruction, 32'hAAAA0001);
    checkOutput("hit_noreq", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("hit_count1", hit_count, 32'd1);

    fetch_valid = 1'b1;
    fetch_pc    = 32'h100;
    tick();
    checkOutput("b2b_word0", {instr_valid, instruction[30:0]}, {1'b1, 31'h2AAA0000});
    fetch_pc = 32'h104;
    tick();
    fetch_valid = 1'b0;
    checkOutput("b2b_word1", {instr_valid, instruction[30:0]}, {1'b1, 31'h2AAA0001});
    tick();
    checkOutput("b2b_idle", {31'd0, instr_valid}, 32'd0);
    checkOutput("b2b_hits", hit_count, 32'd3);

    applyStimulus(1'b1, 32'h180, 1'b0);
    serveMiss("conflict", 32'h180, 32'hBBBB0000, 32'hBBBB0001, 1'b0, 2, 32'hBBBB0000, 1'b0);
    applyStimulus(1'b1, 32'h100, 1'b0);
    serveMiss("conflict_back", 32'h100, 32'hCCCC0000, 32'hCCCC0001, 1'b0, 0, 32'hCCCC0000, 1'b0);
    applyStimulus(1'b1, 32'h10C, 1'b0);
    serveMiss("lastword", 32'h108, 32'hDDDD0000, 32'hDDDD0001, 1'b0, 0, 32'hDDDD0001, 1'b0);
    checkOutput("conflict_misses", miss_count, 32'd4);

    applyStimulus(1'b1, 32'h200, 1'b0);
    serveMiss("errbeat", 32'h200, 32'hEEEE0000, 32'hEEEE0001, 1'b1, 0, 32'hDEADBEEF, 1'b1);
    applyStimulus(1'b1, 32'h200, 1'b0);
    serveMiss("err_refetch", 32'h200, 32'hEEEE0000, 32'hEEEE0001, 1'b0, 0, 32'hEEEE0000, 1'b0);
    applyStimulus(1'b1, 32'h204, 1'b0);
    checkOutput("err_then_hit", {instr_valid, instruction[30:0]}, {1'b1, 31'h6EEE0001});
    checkOutput("err_hits", hit_count, 32'd4);

    applyStimulus(1'b1, 32'h300, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hF0F00000;
    flush      = 1'b1;
    tick();
    flush     = 1'b0;
    mem_rdata = 32'hF0F00001;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("fillflush_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("fillflush_word", instruction, 32'hF0F00000);
    tick();
    applyStimulus(1'b1, 32'h300, 1'b0);
    serveMiss("fillflush_refetch", 32'h300, 32'h11110000, 32'h11110001, 1'b0, 0, 32'h11110000, 1'b0);
    applyStimulus(1'b1, 32'h10C, 1'b0);
    serveMiss("fillflush_other", 32'h108, 32'h22220000, 32'h22220001, 1'b0, 0, 32'h22220001, 1'b0);

    applyStimulus(1'b1, 32'h300, 1'b1);
    serveMiss("idleflush", 32'h300, 32'h33330000, 32'h33330001, 1'b0, 0, 32'h33330000, 1'b0);
    checkOutput("flush_misses", miss_count, 32'd10);
    applyStimulus(1'b1, 32'h300, 1'b0);
    checkOutput("idleflush_hit", {instr_valid, instruction[30:0]}, {1'b1, 31'h33330000});
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h99999999;
    applyStimulus(1'b1, 32'h304, 1'b0);
    mem_rvalid = 1'b0;
    checkOutput("stray_beat_hit", {instr_valid, instruction[30:0]}, {1'b1, 31'h33330001});
    checkOutput("flush_hits", hit_count, 32'd6);

    applyStimulus(1'b1, 32'h400, 1'b0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55550000;
    tick();
    mem_rvalid = 1'b0;
    reset_n    = 1'b0;
    #1;
    checkOutput("midrst_ready", {31'd0, fetch_ready}, 32'd1);
    checkOutput("midrst_reqvalid", {31'd0, mem_req_valid}, 32'd0);
    checkOutput("midrst_reqaddr", mem_req_addr, 32'd0);
    checkOutput("midrst_instr", {instr_valid, instr_err, instruction[29:0]}, 32'd0);
    checkOutput("midrst_counts", hit_count | miss_count, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("midrst_noresp", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'h304, 1'b0);
    serveMiss("postrst", 32'h300, 32'h44440000, 32'h44440001, 1'b0, 0, 32'h44440001, 1'b0);
    checkOutput("postrst_misses", miss_count, 32'd1);
    checkOutput("postrst_hits", hit_count, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
